param_up_dn_cntr: RTL and testbench

PARAM_UP_DN_CNTR -- requirements
Module: param_up_dn_cntr

---
 rtl/param_up_dn_cntr_pkg.sv | 17 +
 rtl/cntr_next_calc.sv | 107 ++++++++++
 rtl/param_up_dn_cntr.sv | 84 ++++++++
 tb/tb_param_up_dn_cntr.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/param_up_dn_cntr_pkg.sv
// Shared encodings for the parameterised up/down counter: count modes and
// the two bounce directions (the bounce state is stored in the dir register).
package param_up_dn_cntr_pkg;

    typedef enum logic [1:0] {
        WRAP   = 2'b00,
        SAT    = 2'b01,
        BOUNCE = 2'b10,
        HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        ST_DN = 1'b0,
        ST_UP = 1'b1
    } bounce_st_e;

endpackage

// File: rtl/cntr_next_calc.sv
// Combinational next-count logic for param_up_dn_cntr: given the current
// count, effective step, direction and mode, produce next count, hit and dir.
module cntr_next_calc
    import param_up_dn_cntr_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] MIN_VAL = '0,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] s,
    input  logic             direction,
    input  mode_e            mode,
    output logic [WIDTH-1:0] next_count,
    output logic             hit,
    output logic             next_dir
);

    // All arithmetic is one bit wider than the count so sums never overflow.
    localparam logic [WIDTH:0] MAX_X = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] MIN_X = {1'b0, MIN_VAL};
    localparam logic [WIDTH:0] RANGE = MAX_X - MIN_X + (WIDTH+1)'(1);

    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] s_x;
    logic [WIDTH:0] up_sum;
    logic [WIDTH:0] dn_diff;
    logic [WIDTH:0] min_plus_s;
    logic [WIDTH:0] wrap_up_val;
    logic [WIDTH:0] wrap_dn_val;

    assign cnt_x       = {1'b0, count};
    assign s_x         = {1'b0, s};
    assign up_sum      = cnt_x + s_x;
    assign dn_diff     = cnt_x - s_x;
    assign min_plus_s  = MIN_X + s_x;
    assign wrap_up_val = up_sum - RANGE;
    assign wrap_dn_val = cnt_x + RANGE - s_x;

    // Underflow is detected as count < MIN+s to avoid a signed subtraction.
    always_comb begin
        next_count = count;
        hit        = 1'b0;
        next_dir   = direction;
        if (s != '0) begin
            unique case (mode)
                WRAP: begin
                    if (direction) begin
                        if (up_sum > MAX_X) begin
                            next_count = wrap_up_val[WIDTH-1:0];
                            hit        = 1'b1;
                        end else begin
                            next_count = up_sum[WIDTH-1:0];
                        end
                    end else begin
                        if (cnt_x < min_plus_s) begin
                            next_count = wrap_dn_val[WIDTH-1:0];
                            hit        = 1'b1;
                        end else begin
                            next_count = dn_diff[WIDTH-1:0];
                        end
                    end
                end
                SAT: begin
                    if (direction) begin
                        if (up_sum > MAX_X) begin
                            next_count = MAX_VAL;
                            hit        = 1'b1;
                        end else begin
                            next_count = up_sum[WIDTH-1:0];
                        end
                    end else begin
                        if (cnt_x < min_plus_s) begin
                            next_count = MIN_VAL;
                            hit        = 1'b1;
                        end else begin
                            next_count = dn_diff[WIDTH-1:0];
                        end
                    end
                end
                BOUNCE: begin
                    if (direction == ST_UP) begin
                        if (up_sum >= MAX_X) begin
                            next_count = MAX_VAL;
                            hit        = 1'b1;
                            next_dir   = ST_DN;
                        end else begin
                            next_count = up_sum[WIDTH-1:0];
                        end
                    end else begin
                        if (cnt_x <= min_plus_s) begin
                            next_count = MIN_VAL;
                            hit        = 1'b1;
                            next_dir   = ST_UP;
                        end else begin
                            next_count = dn_diff[WIDTH-1:0];
                        end
                    end
                end
                HOLD: begin
                    next_count = count;
                end
            endcase
        end
    end

endmodule

// File: rtl/param_up_dn_cntr.sv
// Parameterised up/down counter with wrap, saturate, bounce and hold modes.
// Holds the registers and load/enable priority; arithmetic is in cntr_next_calc.
module param_up_dn_cntr
    import param_up_dn_cntr_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] MIN_VAL = '0,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sense,
    input  logic [WIDTH-1:0] step,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] data_out,
    output logic             dir,
    output logic             at_max,
    output logic             at_min,
    output logic             limit_hit
);

    localparam logic [WIDTH-1:0] SPAN = MAX_VAL - MIN_VAL;

    mode_e            mode_q;
    logic [WIDTH-1:0] s_eff;
    logic             calc_dir;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] calc_next;
    logic             calc_hit;
    logic             calc_next_dir;

    assign mode_q = mode_e'(mode);

    // Bounce mode steers from the stored state; other modes follow sense.
    always_comb begin
        s_eff        = (step > SPAN) ? SPAN : step;
        calc_dir     = (mode_q == BOUNCE) ? dir : sense;
        load_clamped = load_val;
        if (load_val < MIN_VAL) begin
            load_clamped = MIN_VAL;
        end else if (load_val > MAX_VAL) begin
            load_clamped = MAX_VAL;
        end
    end

    cntr_next_calc #(
        .WIDTH   (WIDTH),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL)
    ) u_next_calc (
        .count      (data_out),
        .s          (s_eff),
        .direction  (calc_dir),
        .mode       (mode_q),
        .next_count (calc_next),
        .hit        (calc_hit),
        .next_dir   (calc_next_dir)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out  <= MIN_VAL;
            dir       <= 1'b1;
            limit_hit <= 1'b0;
        end else if (load) begin
            data_out  <= load_clamped;
            dir       <= sense;
            limit_hit <= 1'b0;
        end else if (en && (mode_q != HOLD)) begin
            data_out  <= calc_next;
            dir       <= calc_next_dir;
            limit_hit <= calc_hit;
        end else begin
            limit_hit <= 1'b0;
        end
    end

    assign at_max = (data_out == MAX_VAL);
    assign at_min = (data_out == MIN_VAL);

endmodule

// File: tb/tb_param_up_dn_cntr.sv
// Directed bench for param_up_dn_cntr at WIDTH=4, range [2,12] (R=11);
// every expected value below is worked out by hand from the counter rules.
module tb_param_up_dn_cntr;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             sense;
    logic [WIDTH-1:0] step;
    logic [1:0]       mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] data_out;
    logic             dir;
    logic             at_max;
    logic             at_min;
    logic             limit_hit;

    int checks = 0;
    int errors = 0;

    param_up_dn_cntr #(
        .WIDTH   (WIDTH),
        .MIN_VAL (4'd2),
        .MAX_VAL (4'd12)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sense     (sense),
        .step      (step),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
        .data_out  (data_out),
        .dir       (dir),
        .at_max    (at_max),
        .at_min    (at_min),
        .limit_hit (limit_hit)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Inputs change just after a rising edge, so they are stable at the next one.
    task automatic apply_stimulus(input logic ld, input logic [3:0] lv, input logic e,
                                  input logic sn, input logic [3:0] st, input logic [1:0] md);
        load     = ld;
        load_val = lv;
        en       = e;
        sense    = sn;
        step     = st;
        mode     = md;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input int d, input int dr, input int lh);
        check_output({tag, ".data"}, 32'(data_out), d);
        check_output({tag, ".dir"}, 32'(dir), dr);
        check_output({tag, ".hit"}, 32'(limit_hit), lh);
    endtask

    initial begin
        reset = 1'b0;
        apply_stimulus(0, 0, 0, 0, 0, 0);
        check_output("rst.data", 32'(data_out), 2);
        check_output("rst.dir", 32'(dir), 1);
        check_output("rst.hit", 32'(limit_hit), 0);
        check_output("rst.at_min", 32'(at_min), 1);
        check_output("rst.at_max", 32'(at_max), 0);
        @(negedge clk);
        reset = 1'b1;

        // Wrap up, step 3
        apply_stimulus(1, 11, 1, 1, 3, 2'b00); expect_state("wu0", 11, 1, 0);
        apply_stimulus(0, 0, 1, 1, 3, 2'b00);  expect_state("wu1", 3, 1, 1);
        apply_stimulus(0, 0, 1, 1, 3, 2'b00);  expect_state("wu2", 6, 1, 0);
        apply_stimulus(0, 0, 1, 1, 3, 2'b00);  expect_state("wu3", 9, 1, 0);
        apply_stimulus(0, 0, 1, 1, 3, 2'b00);  expect_state("wu4", 12, 1, 0);
        check_output("wu4.at_max", 32'(at_max), 1);
        apply_stimulus(0, 0, 1, 1, 3, 2'b00);  expect_state("wu5", 4, 1, 1);

        // Wrap down, step 3
        apply_stimulus(1, 3, 1, 0, 3, 2'b00); expect_state("wd0", 3, 0, 0);
        apply_stimulus(0, 0, 1, 0, 3, 2'b00); expect_state("wd1", 11, 0, 1);
        apply_stimulus(0, 0, 1, 0, 3, 2'b00); expect_state("wd2", 8, 0, 0);
        apply_stimulus(0, 0, 1, 0, 3, 2'b00); expect_state("wd3", 5, 0, 0);
        apply_stimulus(0, 0, 1, 0, 3, 2'b00); expect_state("wd4", 2, 0, 0);
        check_output("wd4.at_min", 32'(at_min), 1);
        apply_stimulus(0, 0, 1, 0, 3, 2'b00); expect_state("wd5", 10, 0, 1);

        // Saturate, including a zero step parked at the top bound
        apply_stimulus(1, 10, 1, 1, 4, 2'b01); expect_state("sat0", 10, 1, 0);
        apply_stimulus(0, 0, 1, 1, 4, 2'b01);  expect_state("sat1", 12, 1, 1);
        apply_stimulus(0, 0, 1, 1, 4, 2'b01);  expect_state("sat2", 12, 1, 1);
        apply_stimulus(0, 0, 1, 1, 0, 2'b01);  expect_state("sat_s0", 12, 1, 0);
        apply_stimulus(0, 0, 1, 0, 4, 2'b01);  expect_state("sat3", 8, 0, 0);

        // Bounce; sense is dropped after the load and must be ignored
        apply_stimulus(1, 9, 1, 1, 2, 2'b10); expect_state("bn0", 9, 1, 0);
        apply_stimulus(0, 0, 1, 0, 2, 2'b10); expect_state("bn1", 11, 1, 0);
        apply_stimulus(0, 0, 1, 0, 2, 2'b10); expect_state("bn2", 12, 0, 1);
        apply_stimulus(0, 0, 1, 0, 2, 2'b10); expect_state("bn3", 10, 0, 0);
        apply_stimulus(0, 0, 1, 0, 2, 2'b10); expect_state("bn4", 8, 0, 0);
        apply_stimulus(0, 0, 1, 0, 2, 2'b10); expect_state("bn5", 6, 0, 0);
        apply_stimulus(0, 0, 1, 0, 2, 2'b10); expect_state("bn6", 4, 0, 0);
        apply_stimulus(0, 0, 1, 0, 2, 2'b10); expect_state("bn7", 2, 1, 1);
        apply_stimulus(0, 0, 1, 0, 2, 2'b10); expect_state("bn8", 4, 1, 0);

        // Load clamping, oversized step, and the two hold conditions
        apply_stimulus(1, 15, 1, 1, 1, 2'b00); expect_state("ldhi", 12, 1, 0);
        check_output("ldhi.at_max", 32'(at_max), 1);
        apply_stimulus(1, 0, 1, 0, 1, 2'b00);  expect_state("ldlo", 2, 0, 0);
        check_output("ldlo.at_min", 32'(at_min), 1);
        apply_stimulus(1, 5, 1, 1, 15, 2'b00); expect_state("big0", 5, 1, 0);
        apply_stimulus(0, 0, 1, 1, 15, 2'b00); expect_state("big1", 4, 1, 1);
        apply_stimulus(0, 0, 0, 0, 3, 2'b00);  expect_state("en0", 4, 1, 0);
        apply_stimulus(0, 0, 1, 0, 3, 2'b11);  expect_state("hold", 4, 1, 0);

        // Asynchronous reset mid-count, acting before the next edge
        apply_stimulus(1, 9, 1, 0, 3, 2'b00); expect_state("pre_rst", 9, 0, 0);
        load = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        expect_state("async_rst", 2, 1, 0);
        @(posedge clk);
        #1;
        expect_state("rst_held", 2, 1, 0);
        sense = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        expect_state("rst_rel", 5, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
